// File: rtl/elpis_loader_pkg.sv
// Shared definitions for the Elpis program loader: register map, STATUS layout,
// bus FSM state encoding and print FIFO depth.
// No logic; imported by wb_program_loader and its testbench-visible pieces.
package elpis_loader_pkg;

  // Register offsets, decoded on wbs_adr_i[7:2]
  localparam logic [5:0] REG_CTRL   = 6'd0;
  localparam logic [5:0] REG_ADDR   = 6'd1;
  localparam logic [5:0] REG_DATA   = 6'd2;
  localparam logic [5:0] REG_STATUS = 6'd3;
  localparam logic [5:0] REG_PRINT  = 6'd4;
  localparam logic [5:0] REG_INPUT  = 6'd5;

  // STATUS bit positions; bits [2:0] hold the load FIFO count
  localparam int STAT_OVF_BIT  = 5;
  localparam int STAT_PV_BIT   = 4;
  localparam int STAT_BUSY_BIT = 3;

  // Depth of the optional PRINT queue
  localparam int PRINT_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    BUS_IDLE  = 2'd0,
    BUS_ACK   = 2'd1,
    BUS_STALL = 2'd2
  } bus_state_e;

endpackage

// File: rtl/wb_program_loader_if.sv
// Wishbone slave bundle between a bus master and wb_program_loader.
// Signal names follow the Wishbone _i/_o view of the slave.
// master modport drives the request; slave modport returns ack/read data.
interface wb_program_loader_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/loader_fifo.sv
// Generic synchronous FIFO with occupancy count; head is visible combinationally.
// Latency: a pushed word is at the head on the cycle after the push.
// Backpressure: push while full and pop while empty are ignored; caller checks full/empty.
// Ports: clk, rst (sync, active-high), push/push_dat, pop/pop_dat, full, empty, count.
module loader_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign pop_dat = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
    else if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end
endmodule

// File: rtl/wb_program_loader.sv
// Wishbone-controlled loader: queues {ADDR,DATA} words into core memory, exchanges PRINT/INPUT with Elpis.
// Latency: ack one cycle after the request is sampled; queued words reach core memory one cycle after pop.
// Backpressure: DATA write to a full load FIFO stalls the ack until load_ready drains an entry.
// Ports: wb_clk_i/wb_rst_i; wbs (Wishbone slave); load_* / addr/data_to_core_mem; reset_core; Elpis I/O.
// Build option LOADER_PRINT_FIFO_EN: PRINT backed by a queue instead of a single register.
module wb_program_loader
  import elpis_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          LOAD_DEPTH = 4
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  wb_program_loader_if.slave wbs,
  output logic               is_loading_memory_into_core,
  output logic               load_we,
  input  logic               load_ready,
  output logic [19:0]        addr_to_core_mem,
  output logic [31:0]        data_to_core_mem,
  output logic               reset_core,
  output logic               read_enable_to_Elpis,
  output logic [31:0]        read_value_to_Elpis,
  input  logic               output_enabled_from_elpis_to_controller,
  input  logic [31:0]        output_data_from_elpis_to_controller
);
  localparam int LCW = $clog2(LOAD_DEPTH) + 1;

  bus_state_e  state_q, state_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_o_q, dat_o_d;
  logic        core_reset_q, core_reset_d;
  logic        load_mode_q, load_mode_d;
  logic [19:0] addr_q, addr_d;
  logic [5:0]  req_off_q, req_off_d;
  logic        req_we_q, req_we_d;
  logic [3:0]  req_sel_q, req_sel_d;
  logic [31:0] req_dat_q, req_dat_d;
  logic        load_we_q, load_we_d;
  logic [19:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic        overflow_q, overflow_d;
  logic        rd_en_q, rd_en_d;
  logic [31:0] rd_val_q, rd_val_d;

  logic        hit, commit;
  logic [5:0]  cur_off;
  logic        cur_we;
  logic [3:0]  cur_sel;
  logic [31:0] cur_dat;
  logic [31:0] rd_mux;
  logic        print_rd, capture;
  logic        print_valid;
  logic [31:0] print_rdata;

  logic            lf_push, lf_pop, lf_full, lf_empty;
  logic [51:0]     lf_head, lf_push_dat;
  logic [LCW-1:0]  lf_count;
  logic [31:0]     cnt_ext;

  assign hit     = wbs.wbs_stb_i & wbs.wbs_cyc_i & (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign capture = output_enabled_from_elpis_to_controller;
  assign cnt_ext = 32'(lf_count);

  loader_fifo #(.WIDTH(52), .DEPTH(LOAD_DEPTH)) u_load_fifo (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .push     (lf_push),
    .push_dat (lf_push_dat),
    .pop      (lf_pop),
    .pop_dat  (lf_head),
    .full     (lf_full),
    .empty    (lf_empty),
    .count    (lf_count)
  );

  // A stalled DATA write is served from the latched request, not the live bus.
  always_comb begin
    cur_off = wbs.wbs_adr_i[7:2];
    cur_we  = wbs.wbs_we_i;
    cur_sel = wbs.wbs_sel_i;
    cur_dat = wbs.wbs_dat_i;
    if (state_q == BUS_STALL) begin
      cur_off = req_off_q;
      cur_we  = req_we_q;
      cur_sel = req_sel_q;
      cur_dat = req_dat_q;
    end
  end

  // Bus FSM; commit marks the cycle a request takes effect and ack is scheduled.
  always_comb begin
    state_d   = state_q;
    commit    = 1'b0;
    req_off_d = req_off_q;
    req_we_d  = req_we_q;
    req_sel_d = req_sel_q;
    req_dat_d = req_dat_q;
    case (state_q)
      BUS_IDLE: begin
        if (hit) begin
          req_off_d = wbs.wbs_adr_i[7:2];
          req_we_d  = wbs.wbs_we_i;
          req_sel_d = wbs.wbs_sel_i;
          req_dat_d = wbs.wbs_dat_i;
          if (wbs.wbs_we_i && (wbs.wbs_adr_i[7:2] == REG_DATA) && lf_full) begin
            state_d = BUS_STALL;
          end else begin
            state_d = BUS_ACK;
            commit  = 1'b1;
          end
        end
      end
      BUS_ACK:   state_d = BUS_IDLE;
      BUS_STALL: begin
        if (!lf_full) begin
          state_d = BUS_ACK;
          commit  = 1'b1;
        end
      end
      default:   state_d = BUS_IDLE;
    endcase
  end

  always_comb begin
    rd_mux = 32'd0;
    case (cur_off)
      REG_CTRL:   rd_mux = {30'd0, load_mode_q, core_reset_q};
      REG_ADDR:   rd_mux = {12'd0, addr_q};
      REG_STATUS: begin
        rd_mux[STAT_OVF_BIT]  = overflow_q;
        rd_mux[STAT_PV_BIT]   = print_valid;
        rd_mux[STAT_BUSY_BIT] = is_loading_memory_into_core;
        rd_mux[2:0]           = cnt_ext[2:0];
      end
      REG_PRINT:  rd_mux = print_rdata;
      default:    rd_mux = 32'd0;
    endcase
  end

  assign print_rd    = commit & ~cur_we & (cur_off == REG_PRINT);
  assign lf_pop      = ~lf_empty & load_ready;
  assign lf_push_dat = {addr_q, cur_dat};

`ifdef LOADER_PRINT_FIFO_EN
  logic        pf_full, pf_empty;
  logic [31:0] pf_head;
  logic [$clog2(PRINT_FIFO_DEPTH):0] pf_count;

  loader_fifo #(.WIDTH(32), .DEPTH(PRINT_FIFO_DEPTH)) u_print_fifo (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .push     (capture & ~pf_full),
    .push_dat (output_data_from_elpis_to_controller),
    .pop      (print_rd),
    .pop_dat  (pf_head),
    .full     (pf_full),
    .empty    (pf_empty),
    .count    (pf_count)
  );

  assign print_valid = ~pf_empty;
  assign print_rdata = pf_empty ? 32'd0 : pf_head;
  logic unused_pf;
  assign unused_pf = &{1'b0, pf_count};
`else
  logic        print_q, print_valid_q, print_valid_d;
  logic [31:0] print_dat_q, print_dat_d;
  assign print_valid = print_valid_q;
  assign print_rdata = print_dat_q;
  assign print_q     = 1'b0;
`endif

  always_comb begin
    ack_d        = commit;
    dat_o_d      = dat_o_q;
    core_reset_d = core_reset_q;
    load_mode_d  = load_mode_q;
    addr_d       = addr_q;
    rd_en_d      = 1'b0;
    rd_val_d     = rd_val_q;
    overflow_d   = overflow_q;
    lf_push      = 1'b0;
    load_we_d    = lf_pop;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
`ifndef LOADER_PRINT_FIFO_EN
    print_valid_d = print_valid_q;
    print_dat_d   = print_dat_q;
`endif
    if (lf_pop) {mem_addr_d, mem_data_d} = lf_head;
    if (commit) dat_o_d = cur_we ? 32'd0 : rd_mux;
    if (commit && cur_we) begin
      case (cur_off)
        REG_CTRL: if (cur_sel[0]) {load_mode_d, core_reset_d} = cur_dat[1:0];
        REG_ADDR: begin
          if (cur_sel[0]) addr_d[7:0]   = cur_dat[7:0];
          if (cur_sel[1]) addr_d[15:8]  = cur_dat[15:8];
          if (cur_sel[2]) addr_d[19:16] = cur_dat[19:16];
        end
        REG_DATA: begin
          lf_push = 1'b1;
          addr_d  = addr_q + 20'd1;
        end
        REG_INPUT: begin
          rd_en_d  = 1'b1;
          rd_val_d = cur_dat;
        end
        default: ;
      endcase
    end
    // Clear-on-read comes first so a coincident drop still reports.
    if (commit && !cur_we && (cur_off == REG_STATUS)) overflow_d = 1'b0;
`ifdef LOADER_PRINT_FIFO_EN
    if (capture && pf_full) overflow_d = 1'b1;
`else
    if (print_rd) print_valid_d = 1'b0;
    if (capture) begin
      print_dat_d   = output_data_from_elpis_to_controller;
      print_valid_d = 1'b1;
      if (print_valid_q && !print_rd) overflow_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= BUS_IDLE;
      ack_q        <= 1'b0;
      dat_o_q      <= 32'd0;
      core_reset_q <= 1'b0;
      load_mode_q  <= 1'b0;
      addr_q       <= 20'd0;
      req_off_q    <= 6'd0;
      req_we_q     <= 1'b0;
      req_sel_q    <= 4'd0;
      req_dat_q    <= 32'd0;
      load_we_q    <= 1'b0;
      mem_addr_q   <= 20'd0;
      mem_data_q   <= 32'd0;
      overflow_q   <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_val_q     <= 32'd0;
`ifndef LOADER_PRINT_FIFO_EN
      print_valid_q <= 1'b0;
      print_dat_q   <= 32'd0;
`endif
    end else begin
      state_q      <= state_d;
      ack_q        <= ack_d;
      dat_o_q      <= dat_o_d;
      core_reset_q <= core_reset_d;
      load_mode_q  <= load_mode_d;
      addr_q       <= addr_d;
      req_off_q    <= req_off_d;
      req_we_q     <= req_we_d;
      req_sel_q    <= req_sel_d;
      req_dat_q    <= req_dat_d;
      load_we_q    <= load_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      overflow_q   <= overflow_d;
      rd_en_q      <= rd_en_d;
      rd_val_q     <= rd_val_d;
`ifndef LOADER_PRINT_FIFO_EN
      print_valid_q <= print_valid_d;
      print_dat_q   <= print_dat_d;
`endif
    end
  end

  assign wbs.wbs_ack_o                = ack_q;
  assign wbs.wbs_dat_o                = dat_o_q;
  assign is_loading_memory_into_core  = load_mode_q | ~lf_empty;
  assign reset_core                   = core_reset_q | is_loading_memory_into_core;
  assign load_we                      = load_we_q;
  assign addr_to_core_mem             = mem_addr_q;
  assign data_to_core_mem             = mem_data_q;
  assign read_enable_to_Elpis         = rd_en_q;
  assign read_value_to_Elpis          = rd_val_q;

  logic unused_bits;
  assign unused_bits = &{1'b0, wbs.wbs_adr_i[1:0], cur_sel[3], cnt_ext[31:3]
`ifndef LOADER_PRINT_FIFO_EN
                         , print_q
`endif
                         };
endmodule

// File: doc/wb_program_loader.md
WB_PROGRAM_LOADER -- requirements
Module: wb_program_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000: Wishbone window base; decoded on wbs_adr_i[31:8].
REQ-002 SHALL have parameter LOAD_DEPTH, default 4: load FIFO entries, a power of two.
REQ-003 SHALL have a single clock and a synchronous, active-high reset: wb_clk_i input 1 (sole clock); wb_rst_i input 1 (synchronous, active-high).
REQ-004 SHALL have these Wishbone ports: wbs_stb_i/wbs_cyc_i/wbs_we_i input 1; wbs_sel_i input 4; wbs_adr_i/wbs_dat_i input 32; wbs_ack_o output 1; wbs_dat_o output 32.
REQ-005 SHALL have these core-memory load ports: is_loading_memory_into_core output 1; load_we output 1 (write strobe); load_ready input 1 (from sram_wrapper); addr_to_core_mem output 20; data_to_core_mem output 32.
REQ-006 SHALL have reset_core output 1, holding the core in reset.
REQ-007 SHALL have these core I/O ports: read_enable_to_Elpis output 1; read_value_to_Elpis output 32; output_enabled_from_elpis_to_controller input 1; output_data_from_elpis_to_controller input 32.

Function
REQ-008 SHALL decode registers on wbs_adr_i[7:2]: 0 CTRL (rw; bit0 core_reset, bit1 load_mode); 1 ADDR (rw, 20b); 2 DATA (wo); 3 STATUS (ro); 4 PRINT (ro); 5 INPUT (wo).
REQ-009 SHALL run bus FSM IDLE -> ACK on stb&cyc&window-hit; a DATA write with FIFO full goes IDLE -> STALL; STALL -> ACK once not full; ACK -> IDLE.
REQ-010 SHALL assert wbs_ack_o for exactly one cycle in ACK, one cycle after the request is sampled, and never on consecutive cycles.
REQ-011 SHALL never ack window misses; hits on unmapped offsets ack with read data 0, and writes to them are ignored.
REQ-012 SHALL honour wbs_sel_i per byte on CTRL/ADDR writes only; DATA/INPUT writes are always full-word.
REQ-013 SHALL, on an acked DATA write, push {ADDR, wbs_dat_i} into the FIFO and increment ADDR by 1, wrapping 20'hFFFFF -> 0.
REQ-014 SHALL pop the FIFO head each cycle when load_mode|nonempty and load_ready=1, driving addr/data with load_we high for that cycle.
REQ-015 SHALL hold is_loading_memory_into_core = load_mode | FIFO nonempty; clearing load_mode with entries pending keeps it high until drained.
REQ-016 SHALL hold reset_core = CTRL.core_reset | is_loading_memory_into_core.
REQ-017 SHALL return STATUS = {26'b0, overflow, print_valid, busy, count[2:0]}, where busy = is_loading_memory_into_core.
REQ-018 SHALL capture output_data_from_elpis_to_controller into PRINT, setting print_valid, in the cycle output_enabled_from_elpis_to_controller is high.
REQ-019 SHALL, on a PRINT read, return the value and clear print_valid; a simultaneous new capture wins and print_valid stays 1.
REQ-020 SHALL, on an INPUT write, drive read_value_to_Elpis and pulse read_enable_to_Elpis for one cycle, coincident with ack.

Reset
REQ-021 SHALL clear to 0 on wb_rst_i: FSM (IDLE), wbs_ack_o, wbs_dat_o, CTRL, ADDR, FIFO pointers/count, load_we, PRINT, print_valid, overflow, read_enable_to_Elpis, read_value_to_Elpis; a reset mid-stall or mid-drain discards the pending transfer and FIFO contents.

Configuration
REQ-022 SHALL, with LOADER_PRINT_FIFO_EN defined, back PRINT with a 4-entry FIFO: each read pops one entry, print_valid means nonempty, and a capture while full sets overflow and drops the value.
REQ-023 SHALL, without LOADER_PRINT_FIFO_EN, use a single register: a capture while print_valid overwrites and sets overflow; a STATUS read clears overflow in both builds.

Structure
REQ-024 SHALL take register offsets, the STATUS bit positions, the bus FSM state enum and the print FIFO depth from a shared package, elpis_loader_pkg.
REQ-025 SHALL implement the load queue as one sub-module, loader_fifo: a synchronous FIFO with count output.

Verification
REQ-026 SHALL cover: ADDR<=0x00100, CTRL<=2, DATA 0xA, 0xB, load_ready=1 -> load_we at addrs 0x00100/0x00101 with data A/B, then ADDR reads 0x00102.
REQ-027 SHALL cover: load_ready=0, five DATA writes -> fifth ack stalls; raising load_ready -> fifth acks, and all five words are emitted in order.
REQ-028 SHALL cover: ADDR<=0xFFFFF, two DATA writes -> entries at 0xFFFFF then 0x00000.
REQ-029 SHALL cover: print pulses of 0x11 then 0x22 with no read -> single-register build reads 0x22 with STATUS.overflow=1; FIFO build reads 0x11 then 0x22.
REQ-030 SHALL cover: INPUT<=0xDEADBEEF -> read_enable_to_Elpis high exactly one cycle with value 0xDEADBEEF.
REQ-031 SHALL cover: wb_rst_i asserted during a STALL -> no ack, STATUS reads 0 after reset, reset_core=0.
